victim_cache_wb_ctrl: RTL

Parametrised, fully-associative victim cache controller between the L1 data cache and the memory port. It holds L1-evicted lines in `NUM_WAYS` entries and answers L1 miss probes, invalidating the entry on a hit. It never fetches from memory. Dirty victims go to a one-entry write-back buffer, so an install does not wait for memory. `REPL_MODE` selects the replacement policy: round-robin or oldest-install.

---
 rtl/victim_cache_wb_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/victim_cache_wb_ctrl.sv
// Fully-associative victim cache for L1 evictions. Probes invalidate on hit,
// and dirty victims drain through a one-entry write-back buffer.
module victim_cache_wb_ctrl #(
  parameter int TAG_WIDTH  = 20,
  parameter int LINE_BYTES = 16,
  parameter int NUM_WAYS   = 4,
  parameter int REPL_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         vc_ready,
  input  logic                         probe_valid,
  input  logic [TAG_WIDTH-1:0]         probe_tag,
  output logic                         probe_ready,
  output logic                         probe_hit,
  output logic [LINE_BYTES*8-1:0]      probe_line,
  input  logic                         evict_valid,
  input  logic [TAG_WIDTH-1:0]         evict_tag,
  input  logic [LINE_BYTES*8-1:0]      evict_line,
  input  logic                         evict_dirty,
  output logic                         evict_ready,
  output logic                         mem_req,
  output logic                         mem_req_write,
  output logic [TAG_WIDTH-1:0]         mem_req_tag,
  output logic [LINE_BYTES*8-1:0]      mem_req_wdata,
  input  logic                         mem_resp_valid,
  output logic [$clog2(NUM_WAYS+1)-1:0] occupancy,
  output logic                         wb_busy
);

  localparam int DW = LINE_BYTES * 8;
  localparam int IW = $clog2(NUM_WAYS);
  localparam int OW = $clog2(NUM_WAYS + 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1'b1);
  localparam logic [IW-1:0] AGE_MAX = IW'(NUM_WAYS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_r;
  logic [NUM_WAYS-1:0]   valid_r;
  logic [NUM_WAYS-1:0]   dirty_r;
  logic [TAG_WIDTH-1:0]  tag_r  [NUM_WAYS];
  logic [DW-1:0]         data_r [NUM_WAYS];
  logic [IW-1:0]         age_r  [NUM_WAYS];
  logic [IW-1:0]         repl_ptr_r;
  logic [TAG_WIDTH-1:0]  probe_tag_r;
  logic                  resp_hit_r;
  logic [DW-1:0]         resp_line_r;
  logic                  probe_ready_r;
  logic                  probe_hit_r;
  logic [DW-1:0]         probe_line_r;
  logic                  wb_busy_r;
  logic [TAG_WIDTH-1:0]  wb_tag_r;
  logic [DW-1:0]         wb_data_r;

  logic [NUM_WAYS-1:0]   probe_match_s;
  logic [NUM_WAYS-1:0]   evict_match_s;
  logic                  way_hit_s;
  logic [IW-1:0]         way_hit_idx_s;
  logic                  buf_hit_s;
  logic                  dup_s;
  logic                  full_s;
  logic [IW-1:0]         oldest_idx_s;
  logic [IW-1:0]         policy_idx_s;
  logic [IW-1:0]         slot_s;
  logic [IW-1:0]         old_age_s;
  logic                  use_ptr_s;
  logic                  victim_dirty_s;
  logic                  evict_ready_s;
  logic                  evict_fire_s;

  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_WAYS-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      idx = v[i] ? IW'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [OW-1:0] count_ones(input logic [NUM_WAYS-1:0] v);
    logic [OW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      cnt = cnt + OW'(v[i]);
    end
    return cnt;
  endfunction

  // Per-way tag compares for the captured probe and the offered evict
  always_comb begin
    probe_match_s = '0;
    evict_match_s = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      probe_match_s[i] = valid_r[i] && (tag_r[i] == probe_tag_r);
      evict_match_s[i] = valid_r[i] && (tag_r[i] == evict_tag);
    end
  end

  // Oldest way by age; strict compare keeps the lowest index on ties
  always_comb begin
    oldest_idx_s = '0;
    for (int i = 1; i < NUM_WAYS; i++) begin
      oldest_idx_s = (age_r[i] > age_r[oldest_idx_s]) ? IW'(i) : oldest_idx_s;
    end
  end

  assign way_hit_s     = |probe_match_s;
  assign way_hit_idx_s = lowest_idx(probe_match_s);
  assign buf_hit_s     = wb_busy_r && (wb_tag_r == probe_tag_r);
  assign dup_s         = |evict_match_s;
  assign full_s        = &valid_r;
  assign policy_idx_s  = (REPL_MODE == 1) ? oldest_idx_s : repl_ptr_r;

  // Install slot: in-place duplicate, then lowest free way, then policy victim
  always_comb begin
    slot_s    = policy_idx_s;
    old_age_s = age_r[policy_idx_s];
    if (dup_s) begin
      slot_s    = lowest_idx(evict_match_s);
      old_age_s = age_r[slot_s];
    end else if (!full_s) begin
      slot_s    = lowest_idx(~valid_r);
      old_age_s = AGE_MAX;
    end else begin
      slot_s    = policy_idx_s;
      old_age_s = age_r[policy_idx_s];
    end
  end

  assign use_ptr_s      = !dup_s && full_s && (REPL_MODE == 0);
  assign victim_dirty_s = !dup_s && full_s && dirty_r[slot_s];
  assign evict_ready_s  = rst_n && (state_r == ST_IDLE) && !probe_valid &&
                          !(victim_dirty_s && wb_busy_r);
  assign evict_fire_s   = evict_valid && evict_ready_s;

  // Probe FSM, way storage, ages and write-back buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      valid_r       <= '0;
      dirty_r       <= '0;
      repl_ptr_r    <= '0;
      probe_tag_r   <= '0;
      resp_hit_r    <= 1'b0;
      resp_line_r   <= '0;
      probe_ready_r <= 1'b0;
      probe_hit_r   <= 1'b0;
      probe_line_r  <= '0;
      wb_busy_r     <= 1'b0;
      wb_tag_r      <= '0;
      wb_data_r     <= '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= '0;
        age_r[i]  <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (probe_valid) begin
            state_r     <= ST_LOOKUP;
            probe_tag_r <= probe_tag;
          end
        end
        ST_LOOKUP: begin
          state_r    <= ST_RESP;
          resp_hit_r <= way_hit_s || buf_hit_s;
          resp_line_r <= way_hit_s ? data_r[way_hit_idx_s] :
                         (buf_hit_s ? wb_data_r : '0);
          // L1 takes ownership of a way hit, so the entry and its dirty bit go
          if (way_hit_s) begin
            valid_r[way_hit_idx_s] <= 1'b0;
            dirty_r[way_hit_idx_s] <= 1'b0;
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase

      probe_ready_r <= (state_r == ST_RESP);
      probe_hit_r   <= (state_r == ST_RESP) && resp_hit_r;
      probe_line_r  <= (state_r == ST_RESP) ? resp_line_r : '0;

      if (evict_fire_s) begin
        valid_r[slot_s] <= 1'b1;
        tag_r[slot_s]   <= evict_tag;
        data_r[slot_s]  <= evict_line;
        dirty_r[slot_s] <= dup_s ? (dirty_r[slot_s] | evict_dirty) : evict_dirty;
        if (use_ptr_s) begin
          repl_ptr_r <= repl_ptr_r + IDX_ONE;
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
          if (IW'(i) == slot_s) begin
            age_r[i] <= '0;
          end else if (valid_r[i] && (age_r[i] < old_age_s)) begin
            age_r[i] <= age_r[i] + IDX_ONE;
          end
        end
      end

      if (evict_fire_s && victim_dirty_s) begin
        wb_busy_r <= 1'b1;
        wb_tag_r  <= tag_r[slot_s];
        wb_data_r <= data_r[slot_s];
      end else if (wb_busy_r && mem_resp_valid) begin
        wb_busy_r <= 1'b0;
      end
    end
  end

  assign vc_ready      = (state_r == ST_IDLE);
  assign probe_ready   = probe_ready_r;
  assign probe_hit     = probe_hit_r;
  assign probe_line    = probe_line_r;
  assign evict_ready   = evict_ready_s;
  assign mem_req       = wb_busy_r;
  assign mem_req_write = 1'b1;
  assign mem_req_tag   = wb_tag_r;
  assign mem_req_wdata = wb_data_r;
  assign occupancy     = count_ones(valid_r);
  assign wb_busy       = wb_busy_r;

endmodule
